// File: rtl/stream_demux_pkg.sv
// stream_demux shared types and defaults.
// Counter width applies only when STREAM_DEMUX_COUNT_EN is defined.
package stream_demux_pkg;

  localparam int CNT_W      = 16;
  localparam int DATA_W_DEF = 8;
  localparam int DEPTH_DEF  = 2;

  typedef logic [CNT_W-1:0] cnt_t;

  function automatic cnt_t cnt_inc(cnt_t c);
    return c + cnt_t'(1);
  endfunction

endpackage

// File: rtl/stream_demux_sync_fifo.sv
// Per-port synchronous FIFO for stream_demux.
// Registered head, no bypass, extra pointer MSB for full/empty.
module sync_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] din,
  output logic              full,
  output logic              empty,
  output logic [DATA_W-1:0] head
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW:0]       wr_ptr;
  logic [AW:0]       rd_ptr;
  logic              do_push;
  logic              do_pop;

  // Same index, differing lap bit means the writer is one lap ahead.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                 (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (do_push) begin
        mem[wr_ptr[AW-1:0]] <= din;
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
    end
  end

endmodule

// File: rtl/stream_demux.sv
// One-to-two valid/ready demux with a FIFO per output port.
// Define STREAM_DEMUX_COUNT_EN to add the cnt0/cnt1 pop counters.
module stream_demux
  import stream_demux_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = DEPTH_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_sel,
  input  logic [DATA_W-1:0] in_data,
  output logic              out0_valid,
  input  logic              out0_ready,
  output logic [DATA_W-1:0] out0_data,
  output logic              out1_valid,
  input  logic              out1_ready,
  output logic [DATA_W-1:0] out1_data
`ifdef STREAM_DEMUX_COUNT_EN
  ,
  output cnt_t              cnt0,
  output cnt_t              cnt1
`endif
);

  logic full0;
  logic full1;
  logic empty0;
  logic empty1;
  logic accept;
  logic push0;
  logic push1;
  logic pop0;
  logic pop1;

  // Readiness looks only at the addressed port; no pass-through on pop.
  assign in_ready = in_sel ? !full1 : !full0;
  assign accept   = in_valid && in_ready;
  assign push0    = accept && !in_sel;
  assign push1    = accept && in_sel;

  assign out0_valid = !empty0;
  assign out1_valid = !empty1;
  assign pop0       = out0_valid && out0_ready;
  assign pop1       = out1_valid && out1_ready;

  sync_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo0 (
    .clk   (clk),
    .rst   (rst),
    .push  (push0),
    .pop   (pop0),
    .din   (in_data),
    .full  (full0),
    .empty (empty0),
    .head  (out0_data)
  );

  sync_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo1 (
    .clk   (clk),
    .rst   (rst),
    .push  (push1),
    .pop   (pop1),
    .din   (in_data),
    .full  (full1),
    .empty (empty1),
    .head  (out1_data)
  );

`ifdef STREAM_DEMUX_COUNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt0 <= '0;
      cnt1 <= '0;
    end else begin
      if (pop0) begin
        cnt0 <= cnt_inc(cnt0);
      end
      if (pop1) begin
        cnt1 <= cnt_inc(cnt1);
      end
    end
  end
`endif

endmodule

// File: tb/tb_stream_demux.sv
// Self-checking bench for stream_demux against a queue-based model.
// Counter checks run only when STREAM_DEMUX_COUNT_EN is defined.
module tb_stream_demux;

  localparam int DATA_W = 8;
  localparam int DEPTH  = 2;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic              in_sel = 1'b0;
  logic [DATA_W-1:0] in_data = '0;
  logic              out0_valid;
  logic              out0_ready = 1'b0;
  logic [DATA_W-1:0] out0_data;
  logic              out1_valid;
  logic              out1_ready = 1'b0;
  logic [DATA_W-1:0] out1_data;
`ifdef STREAM_DEMUX_COUNT_EN
  logic [15:0]       cnt0;
  logic [15:0]       cnt1;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  stream_demux #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_sel     (in_sel),
    .in_data    (in_data),
    .out0_valid (out0_valid),
    .out0_ready (out0_ready),
    .out0_data  (out0_data),
    .out1_valid (out1_valid),
    .out1_ready (out1_ready),
    .out1_data  (out1_data)
`ifdef STREAM_DEMUX_COUNT_EN
    ,
    .cnt0       (cnt0),
    .cnt1       (cnt1)
`endif
  );

  // Reference model: one queue per port plus pop tallies.
  logic [7:0]  q0[$];
  logic [7:0]  q1[$];
  logic [15:0] m_cnt0 = '0;
  logic [15:0] m_cnt1 = '0;
  logic        m_acc;

  function automatic logic exp_ready(logic s);
    return s ? (q1.size() < DEPTH) : (q0.size() < DEPTH);
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      q0.delete();
      q1.delete();
      m_cnt0 = '0;
      m_cnt1 = '0;
    end else begin
      m_acc = in_valid && exp_ready(in_sel);
      if (q0.size() > 0 && out0_ready) begin
        void'(q0.pop_front());
        m_cnt0 = m_cnt0 + 16'd1;
      end
      if (q1.size() > 0 && out1_ready) begin
        void'(q1.pop_front());
        m_cnt1 = m_cnt1 + 16'd1;
      end
      if (m_acc) begin
        if (in_sel) q1.push_back(in_data);
        else q0.push_back(in_data);
      end
    end
  end

  task automatic drive(input logic v, input logic s, input logic [7:0] d,
                       input logic r0, input logic r1);
    in_valid   = v;
    in_sel     = s;
    in_data    = d;
    out0_ready = r0;
    out1_ready = r1;
  endtask

  task automatic next_cycle;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (out0_valid !== 1'b0 || out1_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_valid got %b%b want 00", out0_valid, out1_valid);
    end
    checks++;
    if (out0_data !== 8'h00 || out1_data !== 8'h00) begin
      errors++;
      $display("FAIL reset_data got %h/%h want 00/00", out0_data, out1_data);
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready_sel0 got %b want 1", in_ready);
    end
    in_sel = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready_sel1 got %b want 1", in_ready);
    end
`ifdef STREAM_DEMUX_COUNT_EN
    checks++;
    if (cnt0 !== 16'h0 || cnt1 !== 16'h0) begin
      errors++;
      $display("FAIL reset_cnt got %h/%h want 0/0", cnt0, cnt1);
    end
`endif
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_back_to_back;
    drive(1'b1, 1'b0, 8'hA1, 1'b0, 1'b0);
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL b2b_ready_a got %b want 1", in_ready);
    end
    next_cycle();
    drive(1'b1, 1'b1, 8'hB2, 1'b0, 1'b0);
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL b2b_ready_b got %b want 1", in_ready);
    end
    checks++;
    if (out0_valid !== 1'b1 || out0_data !== 8'hA1 || out1_valid !== 1'b0) begin
      errors++;
      $display("FAIL b2b_out0 got v%b %h v1=%b want v1 a1 v1=0",
               out0_valid, out0_data, out1_valid);
    end
    next_cycle();
    drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    @(negedge clk);
    checks++;
    if (out1_valid !== 1'b1 || out1_data !== 8'hB2) begin
      errors++;
      $display("FAIL b2b_out1 got v%b %h want v1 b2", out1_valid, out1_data);
    end
    next_cycle();
    drive(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
    repeat (2) next_cycle();
  endtask

  task automatic test_backpressure;
    drive(1'b1, 1'b0, 8'h10, 1'b0, 1'b1);
    next_cycle();
    drive(1'b1, 1'b0, 8'h11, 1'b0, 1'b1);
    next_cycle();
    drive(1'b1, 1'b0, 8'h12, 1'b0, 1'b1);
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b0 || out0_data !== 8'h10) begin
      errors++;
      $display("FAIL bp_full got rdy=%b head=%h want rdy=0 head=10",
               in_ready, out0_data);
    end
    next_cycle();
    drive(1'b1, 1'b1, 8'h20, 1'b0, 1'b1);
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_port1_ready got %b want 1", in_ready);
    end
    next_cycle();
    drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    @(negedge clk);
    checks++;
    if (out1_valid !== 1'b1 || out1_data !== 8'h20) begin
      errors++;
      $display("FAIL bp_port1_out got v%b %h want v1 20", out1_valid, out1_data);
    end
    next_cycle();
  endtask

  task automatic test_full_pop;
    drive(1'b1, 1'b0, 8'h12, 1'b1, 1'b0);
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b0 || out0_data !== 8'h10) begin
      errors++;
      $display("FAIL fp_pop_cycle got rdy=%b head=%h want rdy=0 head=10",
               in_ready, out0_data);
    end
    next_cycle();
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || out0_data !== 8'h11) begin
      errors++;
      $display("FAIL fp_after_pop got rdy=%b head=%h want rdy=1 head=11",
               in_ready, out0_data);
    end
    next_cycle();
    drive(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    @(negedge clk);
    checks++;
    if (out0_valid !== 1'b1 || out0_data !== 8'h12) begin
      errors++;
      $display("FAIL fp_third got v%b %h want v1 12", out0_valid, out0_data);
    end
    next_cycle();
    @(negedge clk);
    checks++;
    if (out0_valid !== 1'b0) begin
      errors++;
      $display("FAIL fp_drained got v%b want v0", out0_valid);
    end
    next_cycle();
  endtask

  task automatic test_stream_toggle;
    logic [7:0] sent[$];
    logic [7:0] got[$];
    logic       acc;
    int         idx = 0;
    int         cyc = 0;
    for (int i = 0; i < 10; i++) sent.push_back(8'($urandom));
    while (got.size() < 10 && cyc < 200) begin
      drive(idx < 10, 1'b1, (idx < 10) ? sent[idx] : 8'h00,
            1'b0, (cyc % 2) == 0);
      @(negedge clk);
      if (out1_valid && out1_ready) got.push_back(out1_data);
      acc = (idx < 10) && exp_ready(1'b1);
      next_cycle();
      if (acc) idx++;
      cyc++;
    end
    drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    checks++;
    if (got.size() != 10) begin
      errors++;
      $display("FAIL toggle_count got %0d want 10", got.size());
    end
    for (int i = 0; i < 10 && i < got.size(); i++) begin
      checks++;
      if (got[i] !== sent[i]) begin
        errors++;
        $display("FAIL toggle_word%0d got %h want %h", i, got[i], sent[i]);
      end
    end
  endtask

  task automatic test_random;
    logic       v = 1'b0;
    logic       s = 1'b0;
    logic [7:0] d = '0;
    logic       acc = 1'b0;
    for (int c = 0; c < 400; c++) begin
      if (!v || acc) begin
        v = $urandom_range(0, 3) != 0;
        s = 1'($urandom);
        d = 8'($urandom);
      end
      drive(v, s, d, $urandom_range(0, 2) != 0, $urandom_range(0, 1) != 0);
      @(negedge clk);
      checks++;
      if (in_ready !== exp_ready(s)) begin
        errors++;
        $display("FAIL rnd_ready c%0d got %b want %b", c, in_ready, exp_ready(s));
      end
      checks++;
      if (out0_valid !== (q0.size() != 0) ||
          (q0.size() != 0 && out0_data !== q0[0])) begin
        errors++;
        $display("FAIL rnd_out0 c%0d got v%b %h want v%b %h", c, out0_valid,
                 out0_data, q0.size() != 0, (q0.size() != 0) ? q0[0] : 8'h00);
      end
      checks++;
      if (out1_valid !== (q1.size() != 0) ||
          (q1.size() != 0 && out1_data !== q1[0])) begin
        errors++;
        $display("FAIL rnd_out1 c%0d got v%b %h want v%b %h", c, out1_valid,
                 out1_data, q1.size() != 0, (q1.size() != 0) ? q1[0] : 8'h00);
      end
`ifdef STREAM_DEMUX_COUNT_EN
      checks++;
      if (cnt0 !== m_cnt0 || cnt1 !== m_cnt1) begin
        errors++;
        $display("FAIL rnd_cnt c%0d got %h/%h want %h/%h", c, cnt0, cnt1,
                 m_cnt0, m_cnt1);
      end
`endif
      acc = v && exp_ready(s);
      next_cycle();
    end
    drive(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
    repeat (4) next_cycle();
  endtask

  task automatic test_async_reset;
    drive(1'b1, 1'b0, 8'h33, 1'b0, 1'b0);
    next_cycle();
    drive(1'b1, 1'b1, 8'h44, 1'b0, 1'b0);
    next_cycle();
    drive(1'b1, 1'b0, 8'h55, 1'b0, 1'b0);
    next_cycle();
    drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    @(negedge clk);
    checks++;
    if (out0_valid !== 1'b1 || out1_valid !== 1'b1) begin
      errors++;
      $display("FAIL ar_loaded got %b%b want 11", out0_valid, out1_valid);
    end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (out0_valid !== 1'b0 || out1_valid !== 1'b0) begin
      errors++;
      $display("FAIL ar_valid got %b%b want 00", out0_valid, out1_valid);
    end
    checks++;
    if (out0_data !== 8'h00 || out1_data !== 8'h00 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL ar_state got %h/%h rdy=%b want 00/00 rdy=1",
               out0_data, out1_data, in_ready);
    end
    next_cycle();
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (out0_valid !== 1'b0 || out1_valid !== 1'b0) begin
      errors++;
      $display("FAIL ar_release got %b%b want 00", out0_valid, out1_valid);
    end
    next_cycle();
  endtask

`ifdef STREAM_DEMUX_COUNT_EN
  task automatic test_counter;
    int   pushed = 0;
    int   cyc = 0;
    logic acc;
    logic seen_fe = 1'b0;
    logic seen_ff = 1'b0;
    logic seen_00 = 1'b0;
    while (!seen_00 && cyc < 70000) begin
      drive(pushed < 65536, 1'b0, 8'(pushed), 1'b1, 1'b0);
      @(negedge clk);
      if (m_cnt0 == 16'hFFFE && !seen_fe) begin
        seen_fe = 1'b1;
        checks++;
        if (cnt0 !== 16'hFFFE) begin
          errors++;
          $display("FAIL cnt_fffe got %h want fffe", cnt0);
        end
      end else if (seen_fe && !seen_ff) begin
        seen_ff = 1'b1;
        checks++;
        if (cnt0 !== 16'hFFFF) begin
          errors++;
          $display("FAIL cnt_ffff got %h want ffff", cnt0);
        end
      end else if (seen_ff) begin
        seen_00 = 1'b1;
        checks++;
        if (cnt0 !== 16'h0000) begin
          errors++;
          $display("FAIL cnt_wrap got %h want 0000", cnt0);
        end
      end
      acc = (pushed < 65536) && exp_ready(1'b0);
      next_cycle();
      if (acc) pushed++;
      cyc++;
    end
    drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    checks++;
    if (!seen_00) begin
      errors++;
      $display("FAIL cnt_timeout got cycles=%0d want wrap seen", cyc);
    end
  endtask
`endif

  initial begin
    #2_000_000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_back_to_back();
    test_backpressure();
    test_full_pop();
    test_stream_toggle();
    test_random();
    test_async_reset();
`ifdef STREAM_DEMUX_COUNT_EN
    test_counter();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
